// File: rtl/perceptron_sample_loader.sv
// Buffers one training set from a byte stream and replays it EPOCHS times.
// Optional macro LOADER_CHECKSUM_EN adds a running XOR of the loaded bytes on chk.
module perceptron_sample_loader #(
   parameter int N_SAMPLES = 3,
   parameter int INP_DIM   = 2,
   parameter int EPOCHS    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 restart,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic [8*INP_DIM-1:0] s_x,
   output logic [7:0]           s_y,
   output logic [7:0]           s_idx,
   output logic                 s_last,
   output logic                 s_valid,
   input  logic                 s_ready,
   output logic                 done,
   output logic                 ovf,
   output logic [7:0]           chk
);

   localparam int TOT = N_SAMPLES * (INP_DIM + 1);
   localparam int AW  = (TOT > 1) ? $clog2(TOT) : 1;
   localparam logic [AW-1:0] LAST_A = AW'(TOT - 1);
   localparam logic [AW-1:0] STRIDE = AW'(INP_DIM + 1);
   localparam logic [AW-1:0] Y_OFS  = AW'(INP_DIM);
   localparam logic [7:0]    LAST_I = 8'(N_SAMPLES - 1);
   localparam logic [7:0]    LAST_E = 8'(EPOCHS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, REPLAY, DONE} state_t;

   state_t               r_state;
   logic [AW-1:0]        r_addr;
   logic [AW-1:0]        r_rbase;
   logic [7:0]           r_idx;
   logic [7:0]           r_epoch;
   logic                 r_valid;
   logic                 r_last;
   logic                 r_done;
   logic                 r_ovf;
   logic [8*INP_DIM-1:0] r_x;
   logic [7:0]           r_y;
   logic [7:0]           r_mem [TOT];

   logic                 w_acc;
   logic                 w_hs;
   logic                 w_wrap;
   logic                 w_final;
   logic [7:0]           w_pidx;
   logic [AW-1:0]        w_pbase;
   logic [8*INP_DIM-1:0] w_px;
   logic [7:0]           w_py;

   assign w_acc   = ena & ~restart & in_valid &
                    ((r_state == IDLE) | (r_state == LOAD));
   assign w_hs    = r_valid & s_ready;
   assign w_wrap  = (r_idx == LAST_I);
   assign w_final = w_hs & w_wrap & (r_epoch == LAST_E);

   // Sample to present next: the current one on entry, else the successor.
   assign w_pidx  = r_valid ? (w_wrap ? 8'd0 : r_idx + 8'd1) : r_idx;
   assign w_pbase = r_valid ? (w_wrap ? '0 : r_rbase + STRIDE) : r_rbase;

   always_comb begin
      w_px = '0;
      for (int k = 0; k < INP_DIM; k++) begin
         w_px[8*k +: 8] = r_mem[w_pbase + AW'(k)];
      end
      w_py = r_mem[w_pbase + Y_OFS];
   end

   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_mem[r_addr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_rbase <= '0;
         r_idx   <= '0;
         r_epoch <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
      end else if (ena) begin
         if (restart) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rbase <= '0;
            r_idx   <= '0;
            r_epoch <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
         end else begin
            if (in_valid & ((r_state == REPLAY) | (r_state == DONE))) begin
               r_ovf <= 1'b1;
            end
            unique case (r_state)
               IDLE: begin
                  if (in_valid) begin
                     r_addr  <= AW'(1);
                     r_state <= LOAD;
                  end
               end
               LOAD: begin
                  if (in_valid) begin
                     if (r_addr == LAST_A) begin
                        r_state <= REPLAY;
                        r_addr  <= '0;
                        r_rbase <= '0;
                        r_idx   <= '0;
                        r_epoch <= '0;
                     end else begin
                        r_addr <= r_addr + AW'(1);
                     end
                  end
               end
               REPLAY: begin
                  if (w_final) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else if (!r_valid || w_hs) begin
                     r_valid <= 1'b1;
                     r_idx   <= w_pidx;
                     r_rbase <= w_pbase;
                     r_last  <= (w_pidx == LAST_I);
                     r_x     <= w_px;
                     r_y     <= w_py;
                     if (w_hs && w_wrap) begin
                        r_epoch <= r_epoch + 8'd1;
                     end
                  end
               end
               DONE: begin
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] r_chk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chk <= '0;
      end else if (ena) begin
         if (restart) begin
            r_chk <= '0;
         end else if (w_acc) begin
            r_chk <= r_chk ^ in_data;
         end
      end
   end

   assign chk = r_chk;
`else
   assign chk = '0;
`endif

   assign s_x     = r_x;
   assign s_y     = r_y;
   assign s_idx   = r_idx;
   assign s_last  = r_last;
   assign s_valid = r_valid;
   assign done    = r_done;
   assign ovf     = r_ovf;

endmodule

// File: tb/tb_perceptron_sample_loader.sv
// Bench for perceptron_sample_loader: queue model of the replay stream
// plus directed load / stall / overflow / restart / reset scenarios.
module tb_perceptron_sample_loader;

   localparam int N  = 3;
   localparam int D  = 2;
   localparam int EP = 4;
   localparam int NB = N * (D + 1);

   typedef struct packed {
      logic [8*D-1:0] x;
      logic [7:0]     y;
      logic [7:0]     idx;
      logic           last;
   } smp_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           ena = 1'b1;
   logic           restart = 1'b0;
   logic [7:0]     in_data = 8'h00;
   logic           in_valid = 1'b0;
   logic [8*D-1:0] s_x;
   logic [7:0]     s_y;
   logic [7:0]     s_idx;
   logic           s_last;
   logic           s_valid;
   logic           s_ready = 1'b1;
   logic           done;
   logic           ovf;
   logic [7:0]     chk;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic [7:0] ld [NB];
   smp_t exp_q [$];
   logic [7:0] m_chk;
   int   ptr = 0;
   bit   seen = 0;
   bit   mon_on = 0;
   bit   rdy_mode = 0;
   int   cyc = 0;
   smp_t e;

   perceptron_sample_loader #(
      .N_SAMPLES(N), .INP_DIM(D), .EPOCHS(EP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .restart(restart),
      .in_data(in_data), .in_valid(in_valid),
      .s_x(s_x), .s_y(s_y), .s_idx(s_idx), .s_last(s_last),
      .s_valid(s_valid), .s_ready(s_ready),
      .done(done), .ovf(ovf), .chk(chk)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      cyc++;
      s_ready = rdy_mode ? (cyc % 3 == 0) : 1'b1;
   end

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
      end
   endtask

   // Expected stream: every sample of the load, in order, EP times over.
   task automatic build_model();
      smp_t s;
      exp_q.delete();
      m_chk = 8'h00;
      for (int j = 0; j < NB; j++) m_chk ^= ld[j];
      for (int ep = 0; ep < EP; ep++) begin
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < D; k++) s.x[8*k +: 8] = ld[i*(D+1) + k];
            s.y    = ld[i*(D+1) + D];
            s.idx  = 8'(i);
            s.last = (i == N - 1);
            exp_q.push_back(s);
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_on && rst_n) begin
         cmp("done_flag", {31'd0, done}, {31'd0, ptr == exp_q.size()});
         if (ptr < exp_q.size()) begin
            if (seen) cmp("valid_hold", {31'd0, s_valid}, 32'd1);
            if (s_valid) begin
               seen = 1;
               e = exp_q[ptr];
               cmp("s_x", 32'(s_x), 32'(e.x));
               cmp("s_y", 32'(s_y), 32'(e.y));
               cmp("s_idx", 32'(s_idx), 32'(e.idx));
               cmp("s_last", {31'd0, s_last}, {31'd0, e.last});
               if (ena && s_ready && !restart) ptr++;
            end
         end else begin
            cmp("valid_end", {31'd0, s_valid}, 32'd0);
         end
      end
   end

   task automatic do_load();
      build_model();
      ptr = 0;
      seen = 0;
      mon_on = 1;
      for (int j = 0; j < NB; j++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = ld[j];
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      cmp("lat0", {31'd0, s_valid}, 32'd0);
      @(negedge clk);
      cmp("lat1", {31'd0, s_valid}, 32'd1);
   endtask

   task automatic wait_done();
      for (int k = 0; k < 300 && !done; k++) @(negedge clk);
      cmp("done_seen", {31'd0, done}, 32'd1);
   endtask

   task automatic pulse_restart();
      mon_on = 0;
      @(posedge clk); #1;
      restart = 1'b1;
      @(posedge clk); #1;
      restart = 1'b0;
      @(negedge clk);
      cmp("rs_done", {31'd0, done}, 32'd0);
      cmp("rs_valid", {31'd0, s_valid}, 32'd0);
      cmp("rs_ovf", {31'd0, ovf}, 32'd0);
      cmp("rs_idx", 32'(s_idx), 32'd0);
      cmp("rs_chk", 32'(chk), 32'd0);
   endtask

   task automatic check_zero(input string tag);
      cmp({tag, "_x"}, 32'(s_x), 32'd0);
      cmp({tag, "_y"}, 32'(s_y), 32'd0);
      cmp({tag, "_idx"}, 32'(s_idx), 32'd0);
      cmp({tag, "_last"}, {31'd0, s_last}, 32'd0);
      cmp({tag, "_valid"}, {31'd0, s_valid}, 32'd0);
      cmp({tag, "_done"}, {31'd0, done}, 32'd0);
      cmp({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
      cmp({tag, "_chk"}, 32'(chk), 32'd0);
   endtask

   initial begin
      logic [7:0] chk_req;
      ld = '{8'h02, 8'h03, 8'h00, 8'h04, 8'h05, 8'h01, 8'h01, 8'h02, 8'h01};
`ifdef LOADER_CHECKSUM_EN
      chk_req = 8'h03;
`else
      chk_req = 8'h00;
`endif
      #12;
      check_zero("por");
      rst_n = 1'b1;

      // Basic load, s_ready held high
      do_load();
      cmp("first_x", 32'(s_x), 32'h0302);
      cmp("first_y", 32'(s_y), 32'h00);
      cmp("first_idx", 32'(s_idx), 32'd0);
      wait_done();
      cmp("hs_count", ptr, 32'd12);
      cmp("chk_lit", 32'(chk), 32'(chk_req));
      repeat (5) @(negedge clk);
      cmp("done_hold", {31'd0, done}, 32'd1);
      cmp("done_novalid", {31'd0, s_valid}, 32'd0);

      // Stalled replay, overflow byte, ena freeze
      pulse_restart();
      rdy_mode = 1;
      do_load();
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      cmp("ovf_set", {31'd0, ovf}, 32'd1);
      @(posedge clk); #1;
      ena = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      ena = 1'b1;
      wait_done();
      cmp("ovf_sticky", {31'd0, ovf}, 32'd1);
      cmp("chk_stall", 32'(chk), 32'(chk_req));
      rdy_mode = 0;
      pulse_restart();

      // Asynchronous reset after five bytes
      for (int j = 0; j < 5; j++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = ld[j];
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_zero("rst5");
      #2 rst_n = 1'b1;
      do_load();
      wait_done();
      cmp("chk_after_rst", 32'(chk), 32'(chk_req));

      // Restart colliding with a load byte
      pulse_restart();
      for (int j = 0; j < 4; j++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_data  = ld[j];
      end
      @(posedge clk); #1;
      in_data = 8'hAA;
      restart = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      restart  = 1'b0;
      @(negedge clk);
      cmp("coll_valid", {31'd0, s_valid}, 32'd0);
      cmp("coll_chk", 32'(chk), 32'd0);
      ld = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32};
      do_load();
      cmp("coll_first_x", 32'(s_x), 32'h1110);
      cmp("coll_first_y", 32'(s_y), 32'h12);
      wait_done();
`ifdef LOADER_CHECKSUM_EN
      cmp("chk_model", 32'(chk), 32'(m_chk));
`else
      cmp("chk_model", 32'(chk), 32'd0);
`endif

      // Asynchronous reset from DONE with non-zero outputs
      mon_on = 0;
      @(negedge clk);
      rst_n = 1'b0;
      #1 check_zero("rst_done");
      #2 rst_n = 1'b1;

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
